// File: rtl/sfif_wbm_arb.sv
// sfif_wbm_arb: two-requester round-robin Wishbone classic master with retry/timeout handling
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; rN_req/we/adr/dat/sel command
// inputs and rN_done/rdata/status completion outputs per requester; wb_* Wishbone master port;
// busy high outside IDLE; gnt_id is the requester owning the current or last cycle.
module sfif_wbm_arb #(
    parameter int ADR_W     = 18,
    parameter int DAT_W     = 16,
    parameter int TIMEOUT   = 64,
    parameter int RETRY_MAX = 3
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               r0_req,
    input  logic               r0_we,
    input  logic [ADR_W-1:0]   r0_adr,
    input  logic [DAT_W-1:0]   r0_dat,
    input  logic [DAT_W/8-1:0] r0_sel,
    output logic               r0_done,
    output logic [DAT_W-1:0]   r0_rdata,
    output logic [1:0]         r0_status,
    input  logic               r1_req,
    input  logic               r1_we,
    input  logic [ADR_W-1:0]   r1_adr,
    input  logic [DAT_W-1:0]   r1_dat,
    input  logic [DAT_W/8-1:0] r1_sel,
    output logic               r1_done,
    output logic [DAT_W-1:0]   r1_rdata,
    output logic [1:0]         r1_status,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [ADR_W-1:0]   wb_adr_o,
    output logic [DAT_W-1:0]   wb_dat_o,
    output logic [DAT_W/8-1:0] wb_sel_o,
    input  logic [DAT_W-1:0]   wb_dat_i,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    input  logic               wb_rty_i,
    output logic               busy,
    output logic               gnt_id
);
    localparam int SEL_W = DAT_W / 8;
    localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, RWAIT = 2'd2, GAP = 2'd3;

    logic [1:0]       state_q, state_d, done_q, done_d, status0_q, status0_d, status1_q, status1_d;
    logic             last_gnt_q, last_gnt_d, gnt_q, gnt_d, cyc_q, cyc_d, we_q, we_d, busy_q, busy_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [3:0]       rty_q, rty_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] dat_q, dat_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             pick, fin;
    logic [1:0]       fin_st;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        tmo_d      = tmo_q;
        rty_d      = rty_q;
        status0_d  = status0_q;
        status1_d  = status1_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        done_d     = 2'b00;
        fin        = 1'b0;
        fin_st     = 2'b00;
        // on contention the requester that did not win last time gets the bus
        pick       = (r0_req && r1_req) ? ~last_gnt_q : r1_req;
        case (state_q)
            IDLE: if (r0_req || r1_req) begin
                gnt_d      = pick;
                last_gnt_d = pick;
                cyc_d      = 1'b1;
                we_d       = pick ? r1_we : r0_we;
                adr_d      = pick ? r1_adr : r0_adr;
                sel_d      = pick ? r1_sel : r0_sel;
                dat_d      = we_d ? (pick ? r1_dat : r0_dat) : dat_q;
                tmo_d      = '0;
                rty_d      = '0;
                state_d    = BUS;
            end
            BUS: begin
                if (wb_err_i) begin
                    fin    = 1'b1;
                    fin_st = 2'b01;
                end else if (wb_ack_i) begin
                    fin    = 1'b1;
                end else if (wb_rty_i) begin
                    if (rty_q < 4'(RETRY_MAX)) begin
                        cyc_d   = 1'b0;
                        rty_d   = rty_q + 4'd1;
                        state_d = RWAIT;
                    end else begin
                        fin    = 1'b1;
                        fin_st = 2'b11;
                    end
                end else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    fin    = 1'b1;
                    fin_st = 2'b10;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            RWAIT: begin
                cyc_d   = 1'b1;
                tmo_d   = '0;
                state_d = BUS;
            end
            default: state_d = IDLE;
        endcase
        if (fin) begin
            cyc_d   = 1'b0;
            state_d = GAP;
            done_d  = gnt_q ? 2'b10 : 2'b01;
            if (gnt_q) status1_d = fin_st;
            else       status0_d = fin_st;
            // only an ack (status 00) on a read carries data back
            if (fin_st == 2'b00 && !we_q) begin
                if (gnt_q) rdata1_d = wb_dat_i;
                else       rdata0_d = wb_dat_i;
            end
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            tmo_q      <= '0;
            rty_q      <= '0;
            status0_q  <= '0;
            status1_q  <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            tmo_q      <= tmo_d;
            rty_q      <= rty_d;
            status0_q  <= status0_d;
            status1_q  <= status1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign r0_done   = done_q[0];
    assign r1_done   = done_q[1];
    assign r0_rdata  = rdata0_q;
    assign r1_rdata  = rdata1_q;
    assign r0_status = status0_q;
    assign r1_status = status1_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign busy      = busy_q;
    assign gnt_id    = gnt_q;
endmodule

// File: tb/tb_sfif_wbm_arb.sv
// tb_sfif_wbm_arb: scoreboard bench for sfif_wbm_arb with a configurable Wishbone slave model
module tb_sfif_wbm_arb;
    logic        clk = 1'b0, rst = 1'b1;
    logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
    logic [17:0] r0_adr = '0, r1_adr = '0;
    logic [15:0] r0_dat = '0, r1_dat = '0;
    logic [1:0]  r0_sel = '0, r1_sel = '0;
    logic        r0_done, r1_done, wb_cyc_o, wb_stb_o, wb_we_o, busy, gnt_id;
    logic [15:0] r0_rdata, r1_rdata, wb_dat_o, wb_dat_i;
    logic [1:0]  r0_status, r1_status, wb_sel_o;
    logic [17:0] wb_adr_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i, term_now;

    typedef struct { logic [1:0] st; logic chk; logic [15:0] rd; } exp_t;
    typedef struct { int cyc; logic g; } rise_t;
    exp_t  q0[$], q1[$];
    rise_t rises[$];

    int passed = 0, total = 0;
    int attempt_cyc = 0, rty_seen = 0, cyc_hi = 0, adr_hit = 0, cyc_no = 0;
    int wait_n = 1, rty_lim = 0;
    bit never = 0, err_mode = 0, adr_mode = 0;
    logic [15:0] slv_dat = '0;
    logic cyc_d1 = 1'b0;

    always #5 clk = ~clk;

    sfif_wbm_arb dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_adr(r0_adr), .r0_dat(r0_dat), .r0_sel(r0_sel),
        .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_status(r0_status),
        .r1_req(r1_req), .r1_we(r1_we), .r1_adr(r1_adr), .r1_dat(r1_dat), .r1_sel(r1_sel),
        .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_status(r1_status),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .busy(busy), .gnt_id(gnt_id)
    );

    // slave: terminates in cycle wait_n of each attempt; rty_lim rty answers before ack
    assign term_now = wb_cyc_o && wb_stb_o && !never && attempt_cyc == wait_n - 1;
    assign wb_ack_i = term_now && (err_mode || rty_seen >= rty_lim);
    assign wb_err_i = term_now && err_mode;
    assign wb_rty_i = term_now && !err_mode && rty_seen < rty_lim;
    assign wb_dat_i = adr_mode ? {wb_adr_o[7:0], 8'hC3} : slv_dat;

    always @(posedge clk) begin
        attempt_cyc <= wb_cyc_o ? attempt_cyc + 1 : 0;
        rty_seen    <= busy ? rty_seen + int'(wb_rty_i) : 0;
        cyc_hi      <= cyc_hi + int'(wb_cyc_o);
        adr_hit     <= adr_hit + int'(wb_cyc_o && wb_adr_o == 18'h02000);
        cyc_d1      <= wb_cyc_o;
        cyc_no      <= cyc_no + 1;
        if (wb_cyc_o && !cyc_d1) rises.push_back(rise_t'{cyc_no, gnt_id});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic sb_check(input int id, input logic [1:0] st, input logic [15:0] rd);
        exp_t e;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            total++;
            $display("FAIL r%0d unexpected done: status %b rdata %h", id, st, rd);
            return;
        end
        e = id ? q1.pop_front() : q0.pop_front();
        check($sformatf("r%0d status", id), 32'(st), 32'(e.st));
        if (e.chk) check($sformatf("r%0d rdata", id), 32'(rd), 32'(e.rd));
    endtask

    always @(negedge clk) begin
        if (r0_done) sb_check(0, r0_status, r0_rdata);
        if (r1_done) sb_check(1, r1_status, r1_rdata);
    end

    task automatic wait_done(input int id);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? r1_done : r0_done) && n < 500);
        if (n >= 500) begin
            total++;
            $display("FAIL r%0d done wait: got none within 500 cycles, expected a pulse", id);
        end
    endtask

    task automatic cmd(input int id, input logic we, input logic [17:0] adr, input logic [15:0] dat,
                       input logic [1:0] est, input logic chk, input logic [15:0] erd, input bit drop);
        exp_t e;
        e.st = est; e.chk = chk; e.rd = erd;
        if (id) q1.push_back(e); else q0.push_back(e);
        @(negedge clk);
        if (id) begin r1_we = we; r1_adr = adr; r1_dat = dat; r1_sel = 2'b11; r1_req = 1; end
        else    begin r0_we = we; r0_adr = adr; r0_dat = dat; r0_sel = 2'b11; r0_req = 1; end
        wait_done(id);
        if (drop) begin if (id) r1_req = 0; else r0_req = 0; end
    endtask

    task automatic stream(input int id);
        for (int k = 0; k < 4; k++) begin
            logic [17:0] a;
            a = id ? 18'h00210 + 18'(k) : 18'h00100 + 18'(k);
            cmd(id, 0, a, 16'h0, 2'b00, 1, {a[7:0], 8'hC3}, k == 3);
        end
    endtask

    initial begin
        int h0, a0, i0, n;
        repeat (3) @(negedge clk);
        check("reset cyc", 32'(wb_cyc_o), 0);
        check("reset stb", 32'(wb_stb_o), 0);
        check("reset busy", 32'(busy), 0);
        check("reset gnt_id", 32'(gnt_id), 0);
        check("reset done", {30'd0, r1_done, r0_done}, 0);
        rst = 0;

        wait_n = 2; slv_dat = 16'hBEEF; h0 = cyc_hi; a0 = adr_hit;
        cmd(0, 0, 18'h02000, 16'h0, 2'b00, 1, 16'hBEEF, 1);
        check("read cyc cycles", 32'(cyc_hi - h0), 2);
        check("read adr cycles", 32'(adr_hit - a0), 2);
        @(negedge clk);
        check("r0_rdata held", 32'(r0_rdata), 32'h0000BEEF);

        wait_n = 1; rty_lim = 2; slv_dat = 16'h1234; h0 = cyc_hi; i0 = rises.size();
        cmd(1, 0, 18'h00040, 16'h0, 2'b00, 1, 16'h1234, 1);
        check("rty2 strobes", 32'(rises.size() - i0), 3);
        check("rty2 cyc cycles", 32'(cyc_hi - h0), 3);
        if (rises.size() >= i0 + 3) begin
            check("rty2 gap a", 32'(rises[i0 + 1].cyc - rises[i0].cyc), 2);
            check("rty2 gap b", 32'(rises[i0 + 2].cyc - rises[i0 + 1].cyc), 2);
        end
        rty_lim = 100; i0 = rises.size();
        cmd(1, 1, 18'h00044, 16'h5555, 2'b11, 0, 16'h0, 1);
        check("rty exhaust strobes", 32'(rises.size() - i0), 4);

        rty_lim = 0; adr_mode = 1; i0 = rises.size();
        fork
            stream(0);
            stream(1);
        join
        n = rises.size() - i0;
        check("contention grants", 32'(n), 8);
        for (int k = 0; k < 8 && k < n; k++) begin
            check($sformatf("contention gnt %0d", k), 32'(rises[i0 + k].g), 32'(k % 2));
            if (k > 0) check($sformatf("contention spacing %0d", k),
                             32'(rises[i0 + k].cyc - rises[i0 + k - 1].cyc), 3);
        end

        adr_mode = 0; err_mode = 1;
        cmd(0, 0, 18'h00300, 16'h0, 2'b01, 1, 16'h03C3, 1);

        err_mode = 0; never = 1; h0 = cyc_hi;
        cmd(1, 1, 18'h3FFFF, 16'hA5A5, 2'b10, 0, 16'h0, 1);
        check("timeout cyc cycles", 32'(cyc_hi - h0), 64);
        check("timeout busy in gap", 32'(busy), 1);
        @(negedge clk);
        check("timeout busy idle", 32'(busy), 0);
        check("hold we", 32'(wb_we_o), 1);
        check("hold dat", 32'(wb_dat_o), 32'h0000A5A5);
        check("hold adr", 32'(wb_adr_o), 32'h0003FFFF);

        @(negedge clk);
        r0_we = 0; r0_adr = 18'h00500; r0_req = 1;
        n = 0;
        while (!wb_cyc_o && n < 20) begin @(negedge clk); n++; end
        check("reset test cyc up", 32'(wb_cyc_o), 1);
        repeat (3) @(negedge clk);
        #2 rst = 1;
        #1;
        check("async rst cyc", 32'(wb_cyc_o), 0);
        check("async rst stb", 32'(wb_stb_o), 0);
        check("async rst gnt_id", 32'(gnt_id), 0);
        check("async rst busy", 32'(busy), 0);
        check("async rst r0_status", 32'(r0_status), 0);
        never = 0; wait_n = 1; slv_dat = 16'h7777;
        r1_we = 0; r1_adr = 18'h00600; r1_req = 1;
        q0.push_back(exp_t'{2'b00, 1'b1, 16'h7777});
        q1.push_back(exp_t'{2'b00, 1'b1, 16'h7777});
        i0 = rises.size();
        @(negedge clk);
        rst = 0;
        wait_done(0);
        r0_req = 0;
        wait_done(1);
        r1_req = 0;
        check("first grant after reset", rises.size() > i0 ? 32'(rises[i0].g) : 32'd1, 0);

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(q0.size() + q1.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish");
        $fatal(1);
    end
endmodule
